// File: rtl/dct_2d.sv
// Fully pipelined 8x8 forward DCT-II (orthonormal, fixed point): one block in, one block out per clock.
// Stages: input register, row-pass register (T), column-pass register with saturation (data_out).
module dct_2d #(
   parameter int N  = 16,
   parameter int CF = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*64-1:0] data_in,
   output logic [N*64-1:0] data_out
);

   localparam int unsigned TW   = N + 3;
   localparam int unsigned AW   = N + CF + 6;
   localparam int          RND  = 2 ** (CF - 1);
   localparam int          YMAX = (2 ** (N - 1)) - 1;
   localparam int          YMIN = -(2 ** (N - 1));

   // C[k][n] = round(2^CF * a(k) * cos((2n+1)k*pi/16)); table values are the Q8 (CF = 8) set
   localparam int COEF [0:7][0:7] = '{
      '{  91,   91,   91,   91,   91,   91,   91,   91},
      '{ 126,  106,   71,   25,  -25,  -71, -106, -126},
      '{ 118,   49,  -49, -118, -118,  -49,   49,  118},
      '{ 106,  -25, -126,  -71,   71,  126,   25, -106},
      '{  91,  -91,  -91,   91,   91,  -91,  -91,   91},
      '{  71, -126,   25,  106, -106,  -25,  126,  -71},
      '{  49, -118,  118,  -49,  -49,  118, -118,   49},
      '{  25,  -71,  106, -126,  126, -106,   71,  -25}
   };

   logic [N*64-1:0]  x_q;
   logic [TW*64-1:0] t_d, t_q;
   logic [N*64-1:0]  y_d, y_q;

   // Row pass: T[r][k] = floor((sum_n C[k][n]*X[r][n] + 2^(CF-1)) / 2^CF)
   always_comb begin : row_pass
      logic signed [AW-1:0] acc;
      acc = '0;
      t_d = '0;
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 8; k++) begin
            acc = '0;
            for (int n = 0; n < 8; n++) begin
               acc = acc + AW'(COEF[k][n]) * AW'($signed(x_q[(r*8+n)*N +: N]));
            end
            acc = acc + AW'(RND);
            acc = acc >>> CF;
            t_d[(r*8+k)*TW +: TW] = TW'(acc);
         end
      end
   end

   // Column pass with rounding, then clip to the N-bit signed range
   always_comb begin : col_pass
      logic signed [AW-1:0] acc;
      acc = '0;
      y_d = '0;
      for (int v = 0; v < 8; v++) begin
         for (int u = 0; u < 8; u++) begin
            acc = '0;
            for (int r = 0; r < 8; r++) begin
               acc = acc + AW'(COEF[v][r]) * AW'($signed(t_q[(r*8+u)*TW +: TW]));
            end
            acc = acc + AW'(RND);
            acc = acc >>> CF;
            if (acc > AW'(YMAX)) begin
               y_d[(v*8+u)*N +: N] = N'(YMAX);
            end else if (acc < AW'(YMIN)) begin
               y_d[(v*8+u)*N +: N] = N'(YMIN);
            end else begin
               y_d[(v*8+u)*N +: N] = N'(acc);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0;
         t_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= data_in;
         t_q <= t_d;
         y_q <= y_d;
      end
   end

   assign data_out = y_q;

endmodule

// File: tb/tb_dct_2d.sv
// Scoreboard bench for dct_2d: stimulus queues expected blocks with their due cycle,
// a negedge monitor pops and compares every cycle.
module tb_dct_2d;

   localparam int N  = 16;
   localparam int CF = 8;
   localparam int BW = N * 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [BW-1:0] data_in;
   logic [BW-1:0] data_out;

   always #5 clk = ~clk;

   dct_2d #(.N(N), .CF(CF)) dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .data_out (data_out)
   );

   typedef struct {
      int unsigned   due;
      logic [BW-1:0] exp;
      bit [63:0]     tag;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int unsigned cyc   = 0;
   int          tests = 0;
   int          fails = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Coefficient from the defining formula, rounded half away from zero
   function automatic int coef_m(input int k, input int n);
      real a, v;
      a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
      v = real'(2 ** CF) * a * $cos(real'((2 * n + 1) * k) * 3.14159265358979323846 / 16.0);
      if (v >= 0.0) return int'($floor(v + 0.5));
      return -int'($floor(-v + 0.5));
   endfunction

   function automatic logic [BW-1:0] model(input logic [BW-1:0] x);
      longint        t [8][8];
      longint        acc;
      logic [BW-1:0] o;
      o = '0;
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++)
               acc += longint'(coef_m(k, n)) * longint'($signed(x[(r*8+n)*N +: N]));
            t[r][k] = (acc + (64'sd1 <<< (CF - 1))) >>> CF;
         end
      end
      for (int v = 0; v < 8; v++) begin
         for (int u = 0; u < 8; u++) begin
            acc = 0;
            for (int r = 0; r < 8; r++)
               acc += longint'(coef_m(v, r)) * t[r][u];
            acc = (acc + (64'sd1 <<< (CF - 1))) >>> CF;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
            o[(v*8+u)*N +: N] = N'(acc);
         end
      end
      return o;
   endfunction

   function automatic logic [BW-1:0] fill(input int val);
      logic [BW-1:0] o;
      for (int i = 0; i < 64; i++) o[i*N +: N] = N'(val);
      return o;
   endfunction

   // Drive one block for the next edge; a reset edge voids everything still in flight
   task automatic step(input logic [BW-1:0] x, input logic r, input logic [BW-1:0] e,
                       input bit [63:0] tag);
      exp_t it;
      @(negedge clk);
      data_in = x;
      rst     = r;
      if (r) begin
         for (int i = 0; i < q.size(); i++)
            if (q[i].due > cyc) q[i].exp = '0;
      end
      it.due = cyc + 3;
      it.exp = r ? '0 : e;
      it.tag = tag;
      q.push_back(it);
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         int bad;
         mon_e = q.pop_front();
         tests++;
         if (mon_e.due != cyc) begin
            fails++;
            $display("FAIL %s late check at cyc=%0d due=%0d", mon_e.tag, cyc, mon_e.due);
         end else if (data_out !== mon_e.exp) begin
            fails++;
            bad = 0;
            for (int i = 63; i >= 0; i--)
               if (data_out[i*N +: N] !== mon_e.exp[i*N +: N]) bad = i;
            $display("FAIL %s cyc=%0d Y[%0d][%0d] got %0d expected %0d", mon_e.tag, cyc,
                     bad / 8, bad % 8, $signed(data_out[bad*N +: N]),
                     $signed(mon_e.exp[bad*N +: N]));
         end
      end
   end

   initial begin
      logic [BW-1:0] dc_x, dc_e, imp_x, imp_e, neg_e, pos_e, zero;
      logic [BW-1:0] b [4];
      logic [BW-1:0] m [6];
      int            c0 [8];
      int            lane;

      c0   = '{91, 126, 118, 106, 91, 71, 49, 25};
      zero = '0;
      rst  = 1'b1;
      data_in = '0;

      dc_x = fill(100);
      dc_e = '0;
      dc_e[0 +: N] = 16'sd808;

      imp_x = '0;
      imp_x[0 +: N] = 16'sd256;
      imp_e = '0;
      for (int v = 0; v < 8; v++)
         for (int u = 0; u < 8; u++) begin
            lane = (c0[v] * c0[u] + 128) >>> 8;
            imp_e[(v*8+u)*N +: N] = N'(lane);
         end

      neg_e = '0;
      neg_e[0 +: N] = 16'h8000;
      pos_e = '0;
      pos_e[0 +: N] = 16'h7fff;

      for (int i = 0; i < 64; i++) begin
         b[0][i*N +: N] = N'(i * 100 - 3000);
         b[1][i*N +: N] = N'((((i / 8) + (i % 8)) % 2 == 1) ? 1000 : -1000);
         b[2][i*N +: N] = N'($urandom);
         b[3][i*N +: N] = N'($urandom_range(4095, 0) - 2048);
      end
      for (int j = 0; j < 6; j++)
         for (int i = 0; i < 64; i++) m[j][i*N +: N] = N'($urandom_range(20000, 0) - 10000);

      // Reset with garbage on the input
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 64; k++) data_in[k*N +: N] = N'($urandom);
         step(data_in, 1'b1, zero, "reset");
      end

      // Held DC block, then impulse and both saturation extremes
      for (int i = 0; i < 3; i++) step(dc_x, 1'b0, dc_e, "dc");
      step(zero, 1'b0, zero, "idle");
      step(imp_x, 1'b0, imp_e, "impulse");
      step(fill(-32768), 1'b0, neg_e, "sat_neg");
      step(fill(32767), 1'b0, pos_e, "sat_pos");

      // Four distinct blocks back to back
      for (int j = 0; j < 4; j++) step(b[j], 1'b0, model(b[j]), "pipe");

      // Reset pulse with two blocks in flight
      step(m[0], 1'b0, model(m[0]), "pre_rst");
      step(m[1], 1'b0, model(m[1]), "pre_rst");
      step(m[2], 1'b1, zero, "rst_mid");
      for (int j = 3; j < 6; j++) step(m[j], 1'b0, model(m[j]), "post_rst");
      for (int i = 0; i < 3; i++) step(zero, 1'b0, zero, "idle");

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain %0d expected blocks never checked, required 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
